// File: rtl/run_step_ctrl.sv
// Execution-control front end: free-run / debounced N-cycle step bursts / sticky halt
// driven through a single clock enable, plus a registered debug-channel LED view.
// Optional breakpoint compare is enabled by defining RUN_STEP_CTRL_BREAKPOINT_EN.
module run_step_ctrl #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STEP_W          = 8,
   parameter int CNT_W           = 32,
   parameter int LED_W           = 8,
   parameter int NUM_CH          = 8,
   parameter int SEL_W           = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    ena_switch,
   input  logic [STEP_W-1:0]       step_count,
   input  logic                    halt_req,
   input  logic [NUM_CH*LED_W-1:0] ch_data,
   input  logic [SEL_W-1:0]        Switches,
`ifdef RUN_STEP_CTRL_BREAKPOINT_EN
   input  logic                    bp_valid,
   input  logic [31:0]             bp_addr,
   input  logic [31:0]             pc,
`endif
   output logic                    cpu_en,
   output logic                    busy,
   output logic                    step_done,
   output logic [CNT_W-1:0]        en_cycles,
   output logic [LED_W-1:0]        LEDs,
   output logic [1:0]              fsm_state
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      STEP   = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   state_t            state;
   state_t            state_next;
   logic [STEP_W-1:0] remaining;
   logic [STEP_W-1:0] remaining_next;
   logic              done_next;
   logic              s1;
   logic              s2;
   logic              db;
   logic              db_q;
   logic [DB_W-1:0]   db_cnt;
   logic              press;
   logic              halt_hit;
   logic [LED_W-1:0]  led_next;

   // Button: two-stage synchroniser, then a level must hold DEBOUNCE_CYCLES samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         db     <= 1'b0;
         db_q   <= 1'b0;
         db_cnt <= '0;
      end else begin
         s1   <= push;
         s2   <= s1;
         db_q <= db;
         if (s2 == db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            db     <= s2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   assign press = db & ~db_q;

`ifdef RUN_STEP_CTRL_BREAKPOINT_EN
   assign halt_hit = halt_req | (bp_valid & (pc == bp_addr));
`else
   assign halt_hit = halt_req;
`endif

   assign cpu_en    = (state == RUN) || (state == STEP);
   assign busy      = cpu_en;
   assign fsm_state = state;

   always_comb begin
      state_next     = state;
      remaining_next = remaining;
      done_next      = 1'b0;
      case (state)
         IDLE: begin
            if (!ena_switch) begin
               state_next = RUN;
            end else if (press) begin
               state_next     = STEP;
               remaining_next = (step_count == '0) ? STEP_W'(1) : step_count;
            end
         end
         RUN: begin
            if (halt_hit)        state_next = HALTED;
            else if (ena_switch) state_next = IDLE;
         end
         STEP: begin
            remaining_next = remaining - STEP_W'(1);
            if (halt_hit) begin
               state_next = HALTED;
            end else if (remaining == STEP_W'(1)) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         HALTED: begin
            if (press) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // LED view: a selected channel, or a status word when the selector is past the last channel.
   always_comb begin
      led_next = '0;
      if (int'(Switches) < NUM_CH) begin
         led_next = ch_data[int'(Switches)*LED_W +: LED_W];
      end else begin
         led_next[LED_W-1] = busy;
         led_next[LED_W-2] = (state == HALTED);
         led_next[1:0]     = state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= '0;
         step_done <= 1'b0;
         en_cycles <= '0;
         LEDs      <= '0;
      end else begin
         state     <= state_next;
         remaining <= remaining_next;
         step_done <= done_next;
         LEDs      <= led_next;
         if (cpu_en && (en_cycles != '1)) en_cycles <= en_cycles + CNT_W'(1);
      end
   end

endmodule

// File: doc/run_step_ctrl.md
Name: run_step_ctrl

Overview:
- Parametrised execution-control front end for the SIMD FIR processor.
- Replaces the fixed "FPGA clock vs push-button clock" select with a single-clock, clock-enable scheme.
- Modes: free-run, N-cycle step bursts triggered by a debounced button, sticky halt.
- Also drives a registered, selectable debug-channel view onto the board LEDs.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable samples needed to accept a change on push (>=2).
- STEP_W, 8: width of step_count.
- CNT_W, 32: width of the enabled-cycle counter.
- LED_W, 8: LED / debug channel width (>=4).
- NUM_CH, 8: number of debug channels.
- SEL_W, 3: width of the Switches selector.

Ports:
- clk  in  1: system clock (50 MHz board clock).
- reset  in  1: synchronous, active-high reset.
- push  in  1: raw asynchronous push button.
- ena_switch  in  1: 0 = free-run, 1 = step mode.
- step_count  in  STEP_W: cycles per step burst; 0 is treated as 1.
- halt_req  in  1: processor end-of-program / halt request.
- ch_data  in  NUM_CH*LED_W: flattened debug channels; channel k is bits [k*LED_W +: LED_W].
- Switches  in  SEL_W: LED channel select.
- cpu_en  out  1: clock enable for the processor.
- busy  out  1: high in RUN or STEP.
- step_done  out  1: one-cycle pulse when a burst completes.
- en_cycles  out  CNT_W: count of cycles with cpu_en=1.
- LEDs  out  LED_W: registered debug view.

Behaviour:
- Reset (synchronous) takes priority over everything and forces:
  - state=IDLE; cpu_en=0, busy=0, step_done=0, en_cycles=0, LEDs=0.
  - Sync/debounce registers to 0 and remaining=0.
  - Mid-burst or mid-run reset aborts immediately; no step_done is emitted.
- Button path:
  - 2-FF synchroniser s1→s2.
  - Filter: cnt clears whenever s2==db; otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1 and s2!=db: db<=s2, cnt<=0.
  - press = db & ~db_q, a one-cycle pulse.
  - Latency: push stable high before edge t gives press high in cycle t+DEBOUNCE_CYCLES+2.
  - Glitches shorter than DEBOUNCE_CYCLES produce no press.
- FSM states: IDLE, RUN, STEP, HALTED, registered. cpu_en and busy decode from the state register only, so they are glitch-free.
- IDLE:
  - ena_switch=0 → RUN on the next cycle.
  - ena_switch=1 and press → STEP; remaining<=max(step_count,1).
  - cpu_en=0.
- RUN:
  - cpu_en=1.
  - halt_req → HALTED (priority).
  - Otherwise ena_switch=1 → IDLE.
- STEP:
  - cpu_en=1 for exactly remaining cycles; remaining decrements each cycle.
  - On the cycle remaining==1: next state IDLE, and step_done pulses in the first IDLE cycle.
  - halt_req in any STEP cycle → HALTED, with no step_done.
  - press and ena_switch changes are ignored until the burst ends.
- HALTED:
  - cpu_en=0.
  - Sticky; exits to IDLE only on press or reset.
  - halt_req still high after exit re-halts only once the processor is enabled again.
- en_cycles: increments on every cycle with cpu_en=1; saturates at all-ones, no wrap.
- LEDs: registered, 1-cycle latency.
  - Switches < NUM_CH: LEDs <= channel[Switches].
  - Otherwise status word: bit LED_W-1 = busy, LED_W-2 = (state==HALTED), [1:0] = state code (IDLE 0, RUN 1, STEP 2, HALTED 3), other bits 0.

Optional Feature:
- Macro: RUN_STEP_CTRL_BREAKPOINT_EN.
- Defined:
  - Adds ports bp_valid in 1, bp_addr in 32, pc in 32.
  - In RUN or STEP, cpu_en=1 with bp_valid=1 and pc==bp_addr → HALTED next cycle, same as halt_req.
  - Same-cycle halt_req and breakpoint → single HALTED entry.
- Undefined: ports absent; no compare logic.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, step_count=3 unless stated.
- Reset held 3 cycles with ena_switch=0 → cpu_en=0, LEDs=0 during reset; cpu_en=1 from the 2nd cycle after release; en_cycles increments by 1 per cycle.
- ena_switch=1, push high from edge t → press at t+6; cpu_en=1 exactly 3 cycles; step_done pulse once; en_cycles=3; second press during the burst ignored.
- Push glitches of 2-3 cycles, repeated → no press; cpu_en stays 0.
- step_count=0 and a press → exactly 1 enabled cycle, then step_done.
- RUN, then halt_req pulse → HALTED next cycle, cpu_en=0, sticky after halt_req drops. Switches=7 with NUM_CH=7 → LEDs=8'b0100_0011; a press then returns to IDLE.
- Switches=2, ch_data channel 2=8'hA5 → LEDs=8'hA5 one cycle later. Reset asserted mid-burst → cpu_en=0 next cycle and no step_done.
